// File: rtl/mv_bit_window_if.sv
// Bitstream window bus: producer word stream in, 32-bit peek and flush/align control out.
// in_valid/in_ready: a word transfers on any edge where both are high; flush_req/align_req are held until flush_ack.
interface mv_bit_window_if #(
    parameter int WORD_W = 32
);
    logic              in_valid;
    logic [WORD_W-1:0] in_data;
    logic              in_ready;
    logic [31:0]       show_bits;
    logic              show_valid;
    logic              flush_req;
    logic [5:0]        flush_len;
    logic              flush_ack;
    logic              align_req;

    modport master (
        output in_valid, in_data, flush_req, flush_len, align_req,
        input  in_ready, show_bits, show_valid, flush_ack
    );

    modport slave (
        input  in_valid, in_data, flush_req, flush_len, align_req,
        output in_ready, show_bits, show_valid, flush_ack
    );
endinterface

// File: rtl/mv_bit_window.sv
// 64-bit MSB-aligned bit window: loads 32-bit words, exposes the next 32 bits,
// and discards bits on flush or byte alignment of the consumed-bit counter.
module mv_bit_window #(
    parameter int WORD_W = 32
) (
    input  logic         clk,
    input  logic         rst,
    mv_bit_window_if.slave bus,
    output logic [6:0]   bit_count,
    output logic [31:0]  total_bits,
    output logic         err
);
    localparam int WIN_W = 2 * WORD_W;

    logic [WIN_W-1:0] window;
    logic             flush_illegal;
    logic             flush_ok;
    logic [2:0]       align_amt;
    logic             align_ok;
    logic [5:0]       shift_amt;
    logic [6:0]       cnt_after;
    logic [WIN_W-1:0] win_shifted;
    logic             load;

    always_comb begin
        flush_illegal = bus.flush_req && (bus.flush_len > 6'd32);
        flush_ok      = bus.flush_req && !flush_illegal &&
                        ({1'b0, bus.flush_len} <= bit_count);
        // Bits still needed to reach the next byte boundary of the consumed stream.
        align_amt     = 3'd0 - total_bits[2:0];
        align_ok      = !bus.flush_req && bus.align_req &&
                        ({4'b0, align_amt} <= bit_count);
        shift_amt     = 6'd0;
        if (flush_ok)
            shift_amt = bus.flush_len;
        else if (align_ok)
            shift_amt = {3'b0, align_amt};
        cnt_after     = bit_count - {1'b0, shift_amt};
        win_shifted   = window << shift_amt;
        load          = bus.in_valid && bus.in_ready;
    end

    assign bus.in_ready   = (bit_count <= 7'd32);
    assign bus.show_bits  = window[WIN_W-1 -: 32];
    assign bus.show_valid = (bit_count >= 7'd32);
    // Gated by reset so a zero-length request is not acked while held in reset.
    assign bus.flush_ack  = rst && (flush_illegal || flush_ok || align_ok);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            window     <= '0;
            bit_count  <= 7'd0;
            total_bits <= 32'd0;
            err        <= 1'b0;
        end else begin
            if (load) begin
                window    <= win_shifted | ({bus.in_data, {WORD_W{1'b0}}} >> cnt_after);
                bit_count <= cnt_after + 7'd32;
            end else begin
                window    <= win_shifted;
                bit_count <= cnt_after;
            end
            total_bits <= total_bits + {26'b0, shift_amt};
            if (flush_illegal)
                err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mv_bit_window.sv
// Directed bench for mv_bit_window: load/flush/align sequences, illegal and starved flushes, async reset.
module tb_mv_bit_window;
  logic        clk;
  logic        rst;
  logic [6:0]  bit_count;
  logic [31:0] total_bits;
  logic        err;

  int n_assert;
  int n_fail;
  logic [31:0] exp_q[$];

  mv_bit_window_if #(.WORD_W(32)) bus ();

  mv_bit_window #(.WORD_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .bit_count  (bit_count),
    .total_bits (total_bits),
    .err        (err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic drive(input logic v, input logic [31:0] d, input logic fr,
                       input logic [5:0] fl, input logic ar);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.flush_req = fr;
    bus.flush_len = fl;
    bus.align_req = ar;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 6'd0, 1'b0);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // scoreboard
  task automatic expect_val(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    n_assert++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: observed %h with no expected value queued", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
    end
  endtask

  task automatic check_state(input string tag, input logic [31:0] sb, input logic [6:0] bc,
                             input logic [31:0] tb_exp);
    expect_val(sb);
    expect_val({25'b0, bc});
    expect_val(tb_exp);
    chk({tag, ".show_bits"}, bus.show_bits);
    chk({tag, ".bit_count"}, {25'b0, bit_count});
    chk({tag, ".total_bits"}, total_bits);
  endtask

  task automatic check_ack(input string tag, input logic a);
    #1;
    expect_val({31'b0, a});
    chk({tag, ".flush_ack"}, {31'b0, bus.flush_ack});
  endtask

  task automatic check_reset_outputs(input string tag);
    expect_val(32'h0); chk({tag, ".show_bits"},  bus.show_bits);
    expect_val(32'h0); chk({tag, ".show_valid"}, {31'b0, bus.show_valid});
    expect_val(32'h0); chk({tag, ".flush_ack"},  {31'b0, bus.flush_ack});
    expect_val(32'h1); chk({tag, ".in_ready"},   {31'b0, bus.in_ready});
    expect_val(32'h0); chk({tag, ".bit_count"},  {25'b0, bit_count});
    expect_val(32'h0); chk({tag, ".total_bits"}, total_bits);
    expect_val(32'h0); chk({tag, ".err"},        {31'b0, err});
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst = 1'b0;
    idle();
    // zero-length flush held during reset must not be acked
    drive(1'b0, 32'h0, 1'b1, 6'd0, 1'b0);
    #2;
    check_reset_outputs("reset");
    cyc();
    rst = 1'b1;
    idle();

    // two loads fill the window
    drive(1'b1, 32'h00687830, 1'b0, 6'd0, 1'b0);
    cyc();
    drive(1'b1, 32'h4820a0c0, 1'b0, 6'd0, 1'b0);
    cyc();
    idle();
    check_state("load2", 32'h00687830, 7'd64, 32'd0);
    expect_val(32'h1); chk("load2.show_valid", {31'b0, bus.show_valid});
    expect_val(32'h0); chk("load2.in_ready", {31'b0, bus.in_ready});

    drive(1'b0, 32'h0, 1'b1, 6'd8, 1'b0);
    check_ack("flush8", 1'b1);
    cyc();
    idle();
    check_state("flush8", 32'h68783048, 7'd56, 32'd8);

    drive(1'b0, 32'h0, 1'b1, 6'd24, 1'b0);
    check_ack("flush24", 1'b1);
    cyc();
    idle();
    check_state("flush24", 32'h4820a0c0, 7'd32, 32'd32);
    expect_val(32'h1); chk("flush24.in_ready", {31'b0, bus.in_ready});

    // same-cycle flush and load
    drive(1'b1, 32'hc04038f8, 1'b1, 6'd4, 1'b0);
    check_ack("flush4_load", 1'b1);
    cyc();
    idle();
    check_state("flush4_load", 32'h820a0c0c, 7'd60, 32'd36);

    // illegal length: acked, err sticky, state kept
    drive(1'b0, 32'h0, 1'b1, 6'd40, 1'b0);
    check_ack("flush40", 1'b1);
    cyc();
    idle();
    check_state("flush40", 32'h820a0c0c, 7'd60, 32'd36);
    expect_val(32'h1); chk("flush40.err", {31'b0, err});

    drive(1'b0, 32'h0, 1'b1, 6'd0, 1'b0);
    check_ack("flush0", 1'b1);
    cyc();
    idle();
    check_state("flush0", 32'h820a0c0c, 7'd60, 32'd36);
    expect_val(32'h1); chk("flush0.err_sticky", {31'b0, err});

    // asynchronous reset between edges
    drive(1'b0, 32'h0, 1'b1, 6'd0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    cyc();
    rst = 1'b1;
    idle();

    // starved flush
    drive(1'b1, 32'ha5c30f1e, 1'b0, 6'd0, 1'b0);
    cyc();
    drive(1'b0, 32'h0, 1'b1, 6'd24, 1'b0);
    check_ack("pre_starve", 1'b1);
    cyc();
    idle();
    check_state("pre_starve", 32'h1e000000, 7'd8, 32'd24);
    drive(1'b0, 32'h0, 1'b1, 6'd16, 1'b0);
    check_ack("starve_a", 1'b0);
    cyc();
    check_state("starve_a", 32'h1e000000, 7'd8, 32'd24);
    drive(1'b1, 32'h12345678, 1'b1, 6'd16, 1'b0);
    check_ack("starve_load", 1'b0);
    cyc();
    drive(1'b0, 32'h0, 1'b1, 6'd16, 1'b0);
    check_state("starve_load", 32'h1e123456, 7'd40, 32'd24);
    check_ack("starve_done", 1'b1);
    cyc();
    idle();
    check_state("starve_done", 32'h34567800, 7'd24, 32'd40);

    // byte alignment
    rst = 1'b0;
    #1;
    cyc();
    rst = 1'b1;
    drive(1'b1, 32'hffffffff, 1'b0, 6'd0, 1'b0);
    cyc();
    drive(1'b0, 32'h0, 1'b1, 6'd3, 1'b0);
    cyc();
    idle();
    check_state("align_pre", 32'hfffffff8, 7'd29, 32'd3);
    drive(1'b0, 32'h0, 1'b0, 6'd0, 1'b1);
    check_ack("align1", 1'b1);
    cyc();
    check_state("align1", 32'hffffff00, 7'd24, 32'd8);
    check_ack("align2", 1'b1);
    cyc();
    idle();
    check_state("align2", 32'hffffff00, 7'd24, 32'd8);

    // flush has priority over a simultaneous align
    drive(1'b0, 32'h0, 1'b1, 6'd1, 1'b1);
    check_ack("prio", 1'b1);
    cyc();
    idle();
    check_state("prio", 32'hfffffe00, 7'd23, 32'd9);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/mv_bit_window.md
MV_BIT_WINDOW -- requirements
Module: mv_bit_window

Interface
REQ-001 Clocking SHALL be one clock; reset is asynchronous and active-low.
REQ-002 Parameter: WORD_W, default 32, input word width in bits; only 32 is supported.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rst  input  1  asynchronous reset, active-low.
REQ-005 Port: in_valid  input  1  upstream word available.
REQ-006 Port: in_data  input  32  next bitstream word, MSB first.
REQ-007 Port: in_ready  output  1  block accepts in_data this cycle.
REQ-008 Port: show_bits  output  32  next 32 unconsumed bits, MSB = oldest bit; feeds the motion-code and vector decoders.
REQ-009 Port: show_valid  output  1  at least 32 valid bits are held.
REQ-010 Port: flush_req  input  1  consumer requests discard of flush_len bits.
REQ-011 Port: flush_len  input  6  number of bits to discard; legal range 0..32.
REQ-012 Port: flush_ack  output  1  flush or align accepted this cycle.
REQ-013 Port: align_req  input  1  discard bits up to the next byte boundary of total_bits.
REQ-014 Port: bit_count  output  7  valid bits held, 0..64.
REQ-015 Port: total_bits  output  32  running count of consumed bits, wraps modulo 2^32.
REQ-016 Port: err  output  1  sticky flag: illegal flush_len seen.

Function
REQ-017 State SHALL be a 64-bit MSB-aligned window plus bit_count; window bits below the valid region SHALL always be zero.
REQ-018 show_bits SHALL equal window[63:32] combinationally; show_valid SHALL equal (bit_count >= 32).
REQ-019 in_ready SHALL equal (registered bit_count <= 32), combinational from registered state.
REQ-020 On in_valid && in_ready, in_data SHALL be placed at window bits [63-b' : 32-b'], where b' is bit_count after any same-cycle flush; bit_count SHALL increase by 32.
REQ-021 For flush_req with flush_len <= 32 and flush_len <= bit_count, flush_ack SHALL be 1 combinationally; at the edge, the window SHALL shift left by flush_len (zero fill), bit_count SHALL decrease by flush_len, and total_bits SHALL increase by flush_len.
REQ-022 For flush_req with flush_len <= 32 and flush_len > bit_count, flush_ack SHALL be 0 and state SHALL be unchanged; the consumer holds the request.
REQ-023 For flush_req with flush_len > 32, flush_ack SHALL be 1, err SHALL set, and window, bit_count and total_bits SHALL be unchanged.
REQ-024 flush_len = 0 SHALL be acked with no state change.
REQ-025 For align_req with flush_req low, the discard count SHALL be a = (8 - total_bits[2:0]) mod 8; if a <= bit_count, the request SHALL be acked and treated as a flush of a bits; otherwise flush_ack SHALL be 0.
REQ-026 If flush_req and align_req are both high, flush_req SHALL have priority and align_req SHALL be ignored that cycle.
REQ-027 A same-cycle flush and load SHALL both take effect: shift first, then insert at the post-flush position.
REQ-028 bit_count SHALL never exceed 64 and SHALL never go negative.

Reset
REQ-029 When rst is low, the block SHALL asynchronously clear window, bit_count, total_bits and err to 0.
REQ-030 During reset, outputs SHALL be: show_bits = 0, show_valid = 0, flush_ack = 0, in_ready = 1.
REQ-031 An assertion of rst mid-stream SHALL discard all held bits; no partial state SHALL survive.

Verification
REQ-032 Reset, then load 0x00687830 and 0x4820a0c0 -> bit_count = 64, show_bits = 0x00687830, show_valid = 1, in_ready = 0.
REQ-033 Continuing REQ-032: flush 8 -> show_bits = 0x68783048, bit_count = 56, total_bits = 8; then flush 24 -> show_bits = 0x4820a0c0, bit_count = 32, in_ready = 1.
REQ-034 Continuing REQ-033: flush 4 and load 0xc04038f8 in the same cycle -> show_bits = 0x820a0c0c, bit_count = 60, total_bits = 36.
REQ-035 Illegal and starved flushes:
- flush_len = 40 -> flush_ack = 1, err = 1, state unchanged.
- bit_count = 8 with flush 16 -> flush_ack = 0 until a word loads, then ack; bit_count = 24.
REQ-036 Alignment: from reset, load 0xFFFFFFFF, flush 3, align_req -> ack, 5 bits discarded, total_bits = 8, bit_count = 24; a second align_req -> ack with 0 discarded.
REQ-037 Drive rst low asynchronously between edges with bit_count = 60 -> all outputs reach reset values immediately, before the next clk edge.
